// File: rtl/rat_checkpoint_manager_pkg.sv
// Shared defaults and types for the rename-map checkpoint ring.
package rat_checkpoint_manager_pkg;

   localparam int unsigned RAT_CP_SIZE        = 4;
   localparam int unsigned ARF_INT_SIZE       = 32;
   localparam int unsigned PRF_INT_INDEX_SIZE = 6;

   typedef logic [$clog2(RAT_CP_SIZE)-1:0]  cp_index_t;
   typedef logic [PRF_INT_INDEX_SIZE-1:0]   prf_index_t;
   typedef prf_index_t [ARF_INT_SIZE-1:0]   rat_map_t;

endpackage

// File: rtl/rat_checkpoint_manager_cp_snapshot_ram.sv
// Snapshot storage: one sync write port, one sync read port, no reset.
module rat_checkpoint_manager_cp_snapshot_ram #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WIDTH  = 192,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rat_checkpoint_manager.sv
// Ring of rename-map checkpoints: in-order alloc/retire, mispredict squash and
// registered snapshot recovery.
module rat_checkpoint_manager
   import rat_checkpoint_manager_pkg::*;
#(
   parameter int unsigned CP_DEPTH    = RAT_CP_SIZE,
   parameter int unsigned MAP_ENTRIES = ARF_INT_SIZE,
   parameter int unsigned MAP_WIDTH   = PRF_INT_INDEX_SIZE,
   localparam int unsigned CP_IDX_W   = $clog2(CP_DEPTH),
   localparam int unsigned MAP_BITS   = MAP_ENTRIES * MAP_WIDTH
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_alloc_req,
   input  logic [MAP_BITS-1:0] i_alloc_map,
   output logic                o_alloc_gnt,
   output logic [CP_IDX_W-1:0] o_alloc_idx,
   output logic                o_full,
   input  logic                i_resolve_valid,
   input  logic [CP_IDX_W-1:0] i_resolve_idx,
   input  logic                i_resolve_mispredict,
   input  logic                i_flush,
   output logic                o_recover_valid,
   output logic [CP_IDX_W-1:0] o_recover_idx,
   output logic [MAP_BITS-1:0] o_recover_map,
   output logic [CP_DEPTH-1:0] o_valid_mask,
   output logic [CP_IDX_W:0]   o_count
);

   logic [CP_IDX_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [CP_IDX_W:0]   r_count, w_count_nxt;
   logic [CP_DEPTH-1:0] r_valid, r_resolved, w_valid_nxt, w_resolved_nxt;
   logic                r_recover_valid;
   logic [CP_IDX_W-1:0] r_recover_idx;
   logic [MAP_BITS-1:0] w_rd_data;
   logic                w_full, w_mispredict, w_correct, w_retire, w_gnt;
   logic [CP_IDX_W-1:0] w_dist_k;

   assign w_full       = (r_count == (CP_IDX_W+1)'(CP_DEPTH));
   assign w_mispredict = i_resolve_valid & i_resolve_mispredict & r_valid[i_resolve_idx];
   assign w_correct    = i_resolve_valid & ~i_resolve_mispredict & r_valid[i_resolve_idx];
   assign w_gnt        = i_rst_n & i_alloc_req & ~w_full & ~i_flush & ~w_mispredict;
   // The head slot being squashed cannot also retire.
   assign w_retire     = r_valid[r_head] & r_resolved[r_head] &
                         ~(w_mispredict & (i_resolve_idx == r_head));
   assign w_dist_k     = i_resolve_idx - r_head;

   always_comb begin
      w_head_nxt     = r_head;
      w_tail_nxt     = r_tail;
      w_count_nxt    = r_count;
      w_valid_nxt    = r_valid;
      w_resolved_nxt = r_resolved;
      if (w_correct) w_resolved_nxt[i_resolve_idx] = 1'b1;
      if (w_retire) begin
         w_valid_nxt[r_head]    = 1'b0;
         w_resolved_nxt[r_head] = 1'b0;
         w_head_nxt             = r_head + 1'b1;
         w_count_nxt            = r_count - 1'b1;
      end
      if (w_gnt) begin
         w_valid_nxt[r_tail]    = 1'b1;
         w_resolved_nxt[r_tail] = 1'b0;
         w_tail_nxt             = r_tail + 1'b1;
         w_count_nxt            = w_count_nxt + 1'b1;
      end
      if (w_mispredict) begin
         for (int i = 0; i < CP_DEPTH; i++) begin
            if ((CP_IDX_W'(i) - r_head) >= w_dist_k) begin
               w_valid_nxt[i]    = 1'b0;
               w_resolved_nxt[i] = 1'b0;
            end
         end
         w_tail_nxt  = i_resolve_idx;
         w_count_nxt = {1'b0, w_dist_k} - {{CP_IDX_W{1'b0}}, w_retire};
      end
      if (i_flush) begin
         w_head_nxt     = '0;
         w_tail_nxt     = '0;
         w_count_nxt    = '0;
         w_valid_nxt    = '0;
         w_resolved_nxt = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_valid         <= '0;
         r_resolved      <= '0;
         r_recover_valid <= 1'b0;
         r_recover_idx   <= '0;
      end else begin
         r_head          <= w_head_nxt;
         r_tail          <= w_tail_nxt;
         r_count         <= w_count_nxt;
         r_valid         <= w_valid_nxt;
         r_resolved      <= w_resolved_nxt;
         r_recover_valid <= w_mispredict & ~i_flush;
         if (w_mispredict & ~i_flush) r_recover_idx <= i_resolve_idx;
      end
   end

   rat_checkpoint_manager_cp_snapshot_ram #(
      .DEPTH (CP_DEPTH),
      .WIDTH (MAP_BITS)
   ) u_snap_ram (
      .i_clk     (i_clk),
      .i_wr_en   (w_gnt),
      .i_wr_addr (r_tail),
      .i_wr_data (i_alloc_map),
      .i_rd_en   (w_mispredict),
      .i_rd_addr (i_resolve_idx),
      .o_rd_data (w_rd_data)
   );

   // RAM output has no reset; gating by the pulse keeps the port zero otherwise.
   assign o_recover_map   = r_recover_valid ? w_rd_data : '0;
   assign o_recover_valid = r_recover_valid;
   assign o_recover_idx   = r_recover_idx;
   assign o_alloc_gnt     = w_gnt;
   assign o_alloc_idx     = r_tail;
   assign o_full          = w_full;
   assign o_valid_mask    = r_valid;
   assign o_count         = r_count;

endmodule

// File: tb/tb_rat_checkpoint_manager.sv
// Directed bench for rat_checkpoint_manager with hand-computed expectations.
module tb_rat_checkpoint_manager;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         alloc_req;
   logic [191:0] alloc_map;
   logic         alloc_gnt;
   logic [1:0]   alloc_idx;
   logic         full;
   logic         resolve_valid;
   logic [1:0]   resolve_idx;
   logic         resolve_mispredict;
   logic         flush;
   logic         recover_valid;
   logic [1:0]   recover_idx;
   logic [191:0] recover_map;
   logic [3:0]   valid_mask;
   logic [2:0]   count;

   int n_checks = 0;
   int n_errors = 0;

   rat_checkpoint_manager dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_alloc_req          (alloc_req),
      .i_alloc_map          (alloc_map),
      .o_alloc_gnt          (alloc_gnt),
      .o_alloc_idx          (alloc_idx),
      .o_full               (full),
      .i_resolve_valid      (resolve_valid),
      .i_resolve_idx        (resolve_idx),
      .i_resolve_mispredict (resolve_mispredict),
      .i_flush              (flush),
      .o_recover_valid      (recover_valid),
      .o_recover_idx        (recover_idx),
      .o_recover_map        (recover_map),
      .o_valid_mask         (valid_mask),
      .o_count              (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [1:0] idx, input logic mis);
      resolve_valid      = 1'b1;
      resolve_idx        = idx;
      resolve_mispredict = mis;
   endtask

   task automatic resolve_off();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      rst_n = 1'b0; alloc_req = 1'b1; alloc_map = '0; flush = 1'b0;
      resolve_valid = 1'b0; resolve_idx = '0; resolve_mispredict = 1'b0;
      #2;
      chk("gnt_in_reset", 192'(alloc_gnt), 192'(0));
      chk("count_reset", 192'(count), 192'(0));
      chk("mask_reset", 192'(valid_mask), 192'(0));
      chk("rv_reset", 192'(recover_valid), 192'(0));
      chk("rmap_reset", recover_map, 192'(0));
      alloc_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      // Fill the ring with 0x11.., 0x22.., 0x33.., 0x44..
      for (int i = 0; i < 4; i++) begin
         b = 8'((i + 1) * 17);
         alloc_req = 1'b1; alloc_map = {24{b}};
         #1;
         chk("fill_gnt", 192'(alloc_gnt), 192'(1));
         chk("fill_idx", 192'(alloc_idx), 192'(i));
         tick();
      end
      chk("fill_full", 192'(full), 192'(1));
      chk("fill_count", 192'(count), 192'(4));
      chk("fill_mask", 192'(valid_mask), 192'(4'hf));
      #1;
      chk("full_no_gnt", 192'(alloc_gnt), 192'(0));
      alloc_req = 1'b0;

      // Mispredict slot 1 while full
      resolve(2'd1, 1'b1);
      tick();
      resolve_off();
      chk("mp1_rv", 192'(recover_valid), 192'(1));
      chk("mp1_ridx", 192'(recover_idx), 192'(1));
      chk("mp1_rmap", recover_map, {24{8'h22}});
      chk("mp1_mask", 192'(valid_mask), 192'(4'b0001));
      chk("mp1_count", 192'(count), 192'(1));
      chk("mp1_full", 192'(full), 192'(0));
      tick();
      chk("mp1_pulse_end", 192'(recover_valid), 192'(0));
      alloc_req = 1'b1; alloc_map = {24{8'h55}};
      #1;
      chk("mp1_regnt", 192'(alloc_gnt), 192'(1));
      chk("mp1_reidx", 192'(alloc_idx), 192'(1));
      tick();
      alloc_req = 1'b0;

      // Resolve 1 then 0: in-order retire
      resolve(2'd1, 1'b0);
      tick();
      resolve(2'd0, 1'b0);
      tick();
      resolve_off();
      chk("ret_hold_mask", 192'(valid_mask), 192'(4'b0011));
      chk("ret_hold_count", 192'(count), 192'(2));
      tick();
      chk("ret0_mask", 192'(valid_mask), 192'(4'b0010));
      chk("ret0_count", 192'(count), 192'(1));
      tick();
      chk("ret1_mask", 192'(valid_mask), 192'(4'b0000));
      chk("ret1_count", 192'(count), 192'(0));

      // Flush to return pointers to 0
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush0_count", 192'(count), 192'(0));

      // Wrap: slots 0..3 = A0,B0,C0,D0; retire 0,1; refill 0,1 with E0,F0
      for (int i = 0; i < 4; i++) begin
         b = 8'(8'hA0 + 8'(i * 16));
         alloc_req = 1'b1; alloc_map = {24{b}};
         tick();
      end
      alloc_req = 1'b0;
      resolve(2'd0, 1'b0);
      tick();
      resolve(2'd1, 1'b0);
      tick();
      resolve_off();
      chk("wrap_ret0_count", 192'(count), 192'(3));
      tick();
      chk("wrap_ret1_mask", 192'(valid_mask), 192'(4'b1100));
      for (int i = 0; i < 2; i++) begin
         b = 8'(8'hE0 + 8'(i * 16));
         alloc_req = 1'b1; alloc_map = {24{b}};
         #1;
         chk("wrap_idx", 192'(alloc_idx), 192'(i));
         chk("wrap_gnt", 192'(alloc_gnt), 192'(1));
         tick();
      end
      alloc_req = 1'b0;
      chk("wrap_full", 192'(full), 192'(1));
      resolve(2'd3, 1'b1);
      tick();
      resolve_off();
      chk("wrap_mp_mask", 192'(valid_mask), 192'(4'b0100));
      chk("wrap_mp_count", 192'(count), 192'(1));
      chk("wrap_mp_rmap", recover_map, {24{8'hD0}});

      // Alloc request together with a mispredict on head (slot 2)
      alloc_req = 1'b1; alloc_map = {24{8'h77}};
      resolve(2'd2, 1'b1);
      #1;
      chk("mp_blocks_gnt", 192'(alloc_gnt), 192'(0));
      tick();
      resolve_off(); alloc_req = 1'b0;
      chk("mphead_count", 192'(count), 192'(0));
      chk("mphead_ridx", 192'(recover_idx), 192'(2));
      chk("mphead_rmap", recover_map, {24{8'hC0}});
      alloc_req = 1'b1;
      #1;
      chk("mphead_reidx", 192'(alloc_idx), 192'(2));
      tick();
      // Flush with alloc and a mispredict pending
      flush = 1'b1; resolve(2'd2, 1'b1);
      #1;
      chk("flush_blocks_gnt", 192'(alloc_gnt), 192'(0));
      tick();
      flush = 1'b0; resolve_off(); alloc_req = 1'b0;
      chk("flush_count", 192'(count), 192'(0));
      chk("flush_mask", 192'(valid_mask), 192'(0));
      chk("flush_no_rv", 192'(recover_valid), 192'(0));

      // Full ring, mispredict youngest, then reset during the recover pulse
      for (int i = 0; i < 4; i++) begin
         b = 8'(8'h60 + 8'(i));
         alloc_req = 1'b1; alloc_map = {24{b}};
         #1;
         chk("refill_idx", 192'(alloc_idx), 192'(i));
         tick();
      end
      alloc_req = 1'b0;
      resolve(2'd3, 1'b1);
      tick();
      resolve_off();
      chk("young_count", 192'(count), 192'(3));
      chk("young_full", 192'(full), 192'(0));
      chk("young_rv", 192'(recover_valid), 192'(1));
      chk("young_rmap", recover_map, {24{8'h63}});
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rv", 192'(recover_valid), 192'(0));
      chk("arst_ridx", 192'(recover_idx), 192'(0));
      chk("arst_rmap", recover_map, 192'(0));
      chk("arst_count", 192'(count), 192'(0));
      chk("arst_mask", 192'(valid_mask), 192'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      alloc_req = 1'b1; alloc_map = {24{8'h99}};
      #1;
      chk("post_rst_gnt", 192'(alloc_gnt), 192'(1));
      chk("post_rst_idx", 192'(alloc_idx), 192'(0));
      tick();
      alloc_req = 1'b0;
      chk("post_rst_count", 192'(count), 192'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
